// File: rtl/if_id_hazard_register_pkg.sv
// Shared definitions for the IF/ID register: FSM encodings, the nop word and
// the register-field positions used by the hazard compare.
package if_id_hazard_register_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  function automatic logic [4:0] rsField(input logic [31:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [4:0] rtField(input logic [31:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/if_id_hazard_register_hazard_detect.sv
// Pure combinational load-use compare: a load in ID/EX whose destination is a
// source of the instruction sitting in IF/ID. Register 0 never creates a hazard.
module hazard_detect
  import if_id_hazard_register_pkg::*;
(
  input  logic        Valid,
  input  logic        MemRead,
  input  logic [4:0]  Rt,
  input  logic [31:0] Instruction,
  output logic        Hazard
);

  assign Hazard = Valid & MemRead & (Rt != 5'd0) &
                  ((Rt == rsField(Instruction)) | (Rt == rtField(Instruction)));

endmodule

// File: rtl/if_id_hazard_register.sv
// IF/ID pipeline register with load-use stall and taken-branch squash control,
// plus saturating stall/flush performance counters.
module if_id_hazard_register
  import if_id_hazard_register_pkg::*;
#(
  parameter int FLUSH_SLOTS = 1,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [31:0]      PCAdder_In,
  input  logic [31:0]      Instruction_In,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic             BranchTaken,
  output logic [31:0]      PCAdder_reg,
  output logic [31:0]      Instruction_reg,
  output logic             Valid_reg,
  output logic             PCWrite,
  output logic             Bubble,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_SLOTS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     stateReg;
  logic [2:0] flushCnt;
  logic       hazard;

  hazard_detect uHazard (
    .Valid       (Valid_reg),
    .MemRead     (IDEX_MemRead),
    .Rt          (IDEX_Rt),
    .Instruction (Instruction_reg),
    .Hazard      (hazard)
  );

  assign State   = stateReg;
  assign PCWrite = Rst_n & !(hazard & !BranchTaken);
  // The nop already flowing through during FLUSH carries zero control, so no
  // extra bubble is requested there.
  assign Bubble  = !Rst_n | ((stateReg != ST_FLUSH) & (BranchTaken | hazard));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous, seen only at the Clk edge.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      PCAdder_reg     <= '0;
      Instruction_reg <= NOP_INSTR;
      Valid_reg       <= 1'b0;
      stateReg        <= ST_RUN;
      flushCnt        <= '0;
      StallCount      <= '0;
      FlushCount      <= '0;
    end else if (BranchTaken) begin
      PCAdder_reg     <= '0;
      Instruction_reg <= NOP_INSTR;
      Valid_reg       <= 1'b0;
      flushCnt        <= FLUSH_INIT;
      stateReg        <= (FLUSH_SLOTS > 1) ? ST_FLUSH : ST_RUN;
      if (FlushCount != CNT_MAX) FlushCount <= FlushCount + 1'b1;
    end else begin
      case (stateReg)
        ST_FLUSH: begin
          PCAdder_reg     <= '0;
          Instruction_reg <= NOP_INSTR;
          Valid_reg       <= 1'b0;
          flushCnt        <= flushCnt - 3'd1;
          if (flushCnt <= 3'd1) stateReg <= ST_RUN;
        end
        ST_RUN, ST_STALL: begin
          if (hazard) begin
            stateReg <= ST_STALL;
            if (StallCount != CNT_MAX) StallCount <= StallCount + 1'b1;
          end else begin
            PCAdder_reg     <= PCAdder_In;
            Instruction_reg <= Instruction_In;
            Valid_reg       <= 1'b1;
            stateReg        <= ST_RUN;
          end
        end
        default: stateReg <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_hazard_register.sv
// Bench for if_id_hazard_register: a default instance (1 flush slot, 16-bit
// counters) and an alternate one (3 flush slots, 2-bit counters) share inputs.
module tb_if_id_hazard_register;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] PCAdder_In;
  logic [31:0] Instruction_In;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_Rt;
  logic        BranchTaken;

  logic [31:0] mPC, mInstr, aPC, aInstr;
  logic        mValid, mPCWrite, mBubble, aValid, aPCWrite, aBubble;
  logic [1:0]  mState, aState;
  logic [15:0] mStall, mFlush;
  logic [1:0]  aStall, aFlush;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  if_id_hazard_register #(.FLUSH_SLOTS(1), .CNT_W(16)) uMain (
    .Clk(Clk), .Rst_n(Rst_n), .PCAdder_In(PCAdder_In), .Instruction_In(Instruction_In),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .BranchTaken(BranchTaken),
    .PCAdder_reg(mPC), .Instruction_reg(mInstr), .Valid_reg(mValid),
    .PCWrite(mPCWrite), .Bubble(mBubble), .State(mState),
    .StallCount(mStall), .FlushCount(mFlush)
  );

  if_id_hazard_register #(.FLUSH_SLOTS(3), .CNT_W(2)) uAlt (
    .Clk(Clk), .Rst_n(Rst_n), .PCAdder_In(PCAdder_In), .Instruction_In(Instruction_In),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .BranchTaken(BranchTaken),
    .PCAdder_reg(aPC), .Instruction_reg(aInstr), .Valid_reg(aValid),
    .PCWrite(aPCWrite), .Bubble(aBubble), .State(aState),
    .StallCount(aStall), .FlushCount(aFlush)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; BranchTaken = 1'b0; IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0;
    PCAdder_In = '0; Instruction_In = '0;
    tick();
    Rst_n = 1'b1;
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] instr);
    PCAdder_In = pc; Instruction_In = instr;
    tick();
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (2) begin
      PCAdder_In = $urandom; Instruction_In = $urandom;
      IDEX_MemRead = 1'($urandom); IDEX_Rt = 5'($urandom); BranchTaken = 1'($urandom);
      tick();
    end
    checks++;
    if ({mValid, mPC, mInstr, mState, mStall, mFlush} !== '0) begin
      errors++; $display("FAIL reset_main_regs: got v=%b pc=%h i=%h st=%0d sc=%0d fc=%0d expected all 0",
                         mValid, mPC, mInstr, mState, mStall, mFlush);
    end
    checks++;
    if ({aValid, aPC, aInstr, aState, aStall, aFlush} !== '0) begin
      errors++; $display("FAIL reset_alt_regs: got v=%b pc=%h i=%h st=%0d sc=%0d fc=%0d expected all 0",
                         aValid, aPC, aInstr, aState, aStall, aFlush);
    end
    checks++;
    if ({mPCWrite, mBubble, aPCWrite, aBubble} !== 4'b0101) begin
      errors++; $display("FAIL reset_comb: got pcw/bub main=%b%b alt=%b%b expected 01/01",
                         mPCWrite, mBubble, aPCWrite, aBubble);
    end
    Rst_n = 1'b1; BranchTaken = 1'b0; IDEX_MemRead = 1'b0;
    #1;
    checks++;
    if ({mPCWrite, mBubble, aPCWrite, aBubble} !== 4'b1010) begin
      errors++; $display("FAIL reset_release: got pcw/bub main=%b%b alt=%b%b expected 10/10",
                         mPCWrite, mBubble, aPCWrite, aBubble);
    end
  endtask

  // Streams instructions through and scores both instances against a queue.
  task automatic stream(input string name, input int n, input logic first_fixed);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (first_fixed && i == 0) begin
        PCAdder_In = 32'h4; Instruction_In = 32'h012A4020;
      end else begin
        PCAdder_In = $urandom; Instruction_In = $urandom;
      end
      expQ.push_back('{valid: 1'b1, pc: PCAdder_In, instr: Instruction_In});
      tick();
      e = expQ.pop_front();
      checks++;
      if ({mValid, mPC, mInstr} !== e || {aValid, aPC, aInstr} !== e) begin
        errors++; $display("FAIL %s[%0d]: got main=%b/%h/%h alt=%b/%h/%h expected %b/%h/%h",
                           name, i, mValid, mPC, mInstr, aValid, aPC, aInstr, e.valid, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_pass_through();
    do_reset();
    stream("pass_through", 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    stream("back_to_back", 6, 1'b0);
    checks++;
    if (mState !== 2'd0 || mStall !== 16'd0) begin
      errors++; $display("FAIL b2b_state: got st=%0d sc=%0d expected 0/0", mState, mStall);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    load(32'h10, 32'h01095020);
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; PCAdder_In = 32'h14; Instruction_In = 32'hDEADBEEF;
    #1;
    checks++;
    if ({mPCWrite, mBubble, aPCWrite, aBubble} !== 4'b0101) begin
      errors++; $display("FAIL load_use_comb: got pcw/bub main=%b%b alt=%b%b expected 01/01",
                         mPCWrite, mBubble, aPCWrite, aBubble);
    end
    tick();
    checks++;
    if ({mValid, mPC, mInstr} !== {1'b1, 32'h10, 32'h01095020} || mState !== 2'd1 || mStall !== 16'd1) begin
      errors++; $display("FAIL load_use_hold: got v=%b pc=%h i=%h st=%0d sc=%0d expected 1/10/01095020/1/1",
                         mValid, mPC, mInstr, mState, mStall);
    end
    IDEX_MemRead = 1'b0;
    #1;
    checks++;
    if ({mPCWrite, mBubble} !== 2'b10) begin
      errors++; $display("FAIL load_use_clear: got pcw/bub=%b%b expected 10", mPCWrite, mBubble);
    end
    tick();
    checks++;
    if ({mValid, mPC, mInstr} !== {1'b1, 32'h14, 32'hDEADBEEF} || mState !== 2'd0 || aStall !== 2'd1) begin
      errors++; $display("FAIL load_use_resume: got v=%b pc=%h i=%h st=%0d alt_sc=%0d expected 1/14/deadbeef/0/1",
                         mValid, mPC, mInstr, mState, aStall);
    end
  endtask

  task automatic test_no_false_hazard();
    do_reset();
    load(32'h20, 32'h00004020);
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0;
    PCAdder_In = 32'h24; Instruction_In = 32'h11111111;
    #1;
    checks++;
    if ({mPCWrite, mBubble} !== 2'b10) begin
      errors++; $display("FAIL rt_zero_comb: got pcw/bub=%b%b expected 10", mPCWrite, mBubble);
    end
    tick();
    checks++;
    if ({mValid, mPC, mInstr} !== {1'b1, 32'h24, 32'h11111111} || mStall !== 16'd0) begin
      errors++; $display("FAIL rt_zero_load: got v=%b pc=%h i=%h sc=%0d expected 1/24/11111111/0",
                         mValid, mPC, mInstr, mStall);
    end
    // 0x11111111 has rs=8, rt=17: a non-matching register must not stall.
    IDEX_Rt = 5'd5;
    #1;
    checks++;
    if (mPCWrite !== 1'b1) begin
      errors++; $display("FAIL nonmatch_rt: got pcw=%b expected 1", mPCWrite);
    end
    IDEX_Rt = 5'd17;
    #1;
    checks++;
    if ({mPCWrite, mBubble} !== 2'b01) begin
      errors++; $display("FAIL rt_field_match: got pcw/bub=%b%b expected 01", mPCWrite, mBubble);
    end
    IDEX_MemRead = 1'b0;
    #1;
    checks++;
    if ({mPCWrite, mBubble} !== 2'b10) begin
      errors++; $display("FAIL no_memread: got pcw/bub=%b%b expected 10", mPCWrite, mBubble);
    end
  endtask

  task automatic test_branch_hazard();
    logic [31:0] pc, ins;
    do_reset();
    load(32'h30, 32'h01095020);
    BranchTaken = 1'b1; IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8;
    PCAdder_In = 32'h34; Instruction_In = 32'hAAAA0001;
    #1;
    checks++;
    if ({mPCWrite, mBubble, aPCWrite, aBubble} !== 4'b1111) begin
      errors++; $display("FAIL branch_hazard_comb: got pcw/bub main=%b%b alt=%b%b expected 11/11",
                         mPCWrite, mBubble, aPCWrite, aBubble);
    end
    tick();
    checks++;
    if ({mValid, mPC, mInstr, aValid, aPC, aInstr} !== '0 || mFlush !== 16'd1 || aFlush !== 2'd1 ||
        mStall !== 16'd0 || aStall !== 2'd0 || mState !== 2'd0 || aState !== 2'd2) begin
      errors++; $display("FAIL branch_squash: got mv=%b av=%b fc=%0d/%0d sc=%0d/%0d st=%0d/%0d expected 0/0 1/1 0/0 0/2",
                         mValid, aValid, mFlush, aFlush, mStall, aStall, mState, aState);
    end
    BranchTaken = 1'b0; IDEX_MemRead = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      pc = 32'h100 + 32'(4 * k); ins = 32'hB0000000 + 32'(k);
      load(pc, ins);
      checks++;
      if ({mValid, mPC, mInstr} !== {1'b1, pc, ins}) begin
        errors++; $display("FAIL branch_main_slot%0d: got v=%b pc=%h i=%h expected 1/%h/%h",
                           k, mValid, mPC, mInstr, pc, ins);
      end
      checks++;
      if ((k <= 2) ? (aValid !== 1'b0 || aInstr !== 32'h0) : ({aValid, aPC, aInstr} !== {1'b1, pc, ins})) begin
        errors++; $display("FAIL branch_alt_slot%0d: got v=%b pc=%h i=%h st=%0d expected %s",
                           k, aValid, aPC, aInstr, aState, (k <= 2) ? "squashed" : "loaded");
      end
    end
  endtask

  task automatic test_flush_restart();
    do_reset();
    BranchTaken = 1'b1;
    tick();
    #1;
    checks++;
    if ({mBubble, aBubble} !== 2'b10) begin
      errors++; $display("FAIL flush_bubble: got bub main=%b alt=%b expected 1/0", mBubble, aBubble);
    end
    tick();
    BranchTaken = 1'b0;
    checks++;
    if (aFlush !== 2'd2 || mFlush !== 16'd2 || aState !== 2'd2) begin
      errors++; $display("FAIL flush_restart_cnt: got fc=%0d/%0d st=%0d expected 2/2/2", mFlush, aFlush, aState);
    end
    load(32'h200, 32'h22222222);
    load(32'h204, 32'h33333333);
    checks++;
    if (aValid !== 1'b0 || aState !== 2'd0) begin
      errors++; $display("FAIL flush_restart_tail: got v=%b st=%0d expected 0/0", aValid, aState);
    end
    load(32'h208, 32'h44444444);
    checks++;
    if ({aValid, aPC, aInstr} !== {1'b1, 32'h208, 32'h44444444}) begin
      errors++; $display("FAIL flush_restart_resume: got v=%b pc=%h i=%h expected 1/208/44444444",
                         aValid, aPC, aInstr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load(32'h40, 32'h01095020);
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8;
    tick();
    BranchTaken = 1'b1; IDEX_MemRead = 1'b0;
    tick();
    BranchTaken = 1'b0; Rst_n = 1'b0;
    tick();
    checks++;
    if ({aValid, aPC, aInstr, aState, aStall, aFlush, mStall, mFlush} !== '0) begin
      errors++; $display("FAIL reset_mid: got v=%b st=%0d sc=%0d/%0d fc=%0d/%0d expected all 0",
                         aValid, aState, mStall, aStall, mFlush, aFlush);
    end
    Rst_n = 1'b1;
    load(32'h50, 32'h55555555);
    checks++;
    if ({aValid, aPC, aInstr} !== {1'b1, 32'h50, 32'h55555555} || aState !== 2'd0) begin
      errors++; $display("FAIL reset_mid_resume: got v=%b pc=%h i=%h st=%0d expected 1/50/55555555/0",
                         aValid, aPC, aInstr, aState);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    load(32'h60, 32'h01095020);
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8;
    repeat (5) tick();
    checks++;
    if (aStall !== 2'd3 || mStall !== 16'd5 || aState !== 2'd1) begin
      errors++; $display("FAIL saturation: got sc alt=%0d main=%0d st=%0d expected 3/5/1", aStall, mStall, aState);
    end
    IDEX_MemRead = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0; BranchTaken = 1'b0; IDEX_MemRead = 1'b0; IDEX_Rt = '0;
    PCAdder_In = '0; Instruction_In = '0;
    @(negedge Clk);
    test_reset();
    test_pass_through();
    test_back_to_back();
    test_load_use();
    test_no_false_hazard();
    test_branch_hazard();
    test_flush_restart();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_register.md
# if_id_hazard_register

IF/ID pipeline register with integrated load-use hazard detection and branch-flush control. Captures PC+4 and the fetched instruction each cycle, stalls itself and the PC on a load-use hazard against the instruction held in ID/EX, and squashes wrong-path fetches after a taken branch. It sits directly upstream of the ID/EX register. Its `Bubble` output forces zero control signals into ID/EX.

## Interface
- `FLUSH_SLOTS`, default 1: cycles IF/ID is squashed after a taken branch; legal range 1–7.
- `CNT_W`, default 16: width of the saturating performance counters.

Ports:
- `Clk` in 1: single clock, posedge.
- `Rst_n` in 1: reset, synchronous, active-low.
- `PCAdder_In` in 32: PC+4 from IF.
- `Instruction_In` in 32: instruction from instruction memory.
- `IDEX_MemRead` in 1: `MemRead_reg` of ID/EX.
- `IDEX_Rt` in 5: `Instruction20_16_reg` of ID/EX.
- `BranchTaken` in 1: branch resolved taken this cycle.
- `PCAdder_reg` out 32: registered PC+4 to ID.
- `Instruction_reg` out 32: registered instruction to ID.
- `Valid_reg` out 1: IF/ID holds a real instruction.
- `PCWrite` out 1: PC update enable; combinational.
- `Bubble` out 1: zero the ID/EX control inputs this cycle; combinational.
- `State` out 2: FSM state for debug.
- `StallCount` out `CNT_W`: count of stall cycles, saturating.
- `FlushCount` out `CNT_W`: count of taken-branch events, saturating.

## Operation
Hazard condition:
- hazard = `Valid_reg` & `IDEX_MemRead` & (`IDEX_Rt` != 0) & (`IDEX_Rt` == `Instruction_reg[25:21]` | `IDEX_Rt` == `Instruction_reg[20:16]`).

FSM states:
- RUN = 0
- STALL = 1
- FLUSH = 2
- Encoding 3 is unused and recovers to RUN on the next edge.

Per-edge priority, highest first:
1. `Rst_n` = 0: all registers 0, State = RUN, flush counter 0, both perf counters 0.
2. `BranchTaken`:
   - `Instruction_reg` <= 0 (nop), `PCAdder_reg` <= 0, `Valid_reg` <= 0.
   - `FlushCount` increments.
   - Flush counter <= `FLUSH_SLOTS` - 1.
   - Next State = FLUSH if `FLUSH_SLOTS` > 1, else RUN.
3. State == FLUSH:
   - Load nop and `Valid_reg` <= 0 as in step 2.
   - Decrement the flush counter; go to RUN when it reaches 0.
   - A hazard is ignored in this state, because `Valid_reg` = 0 makes it false by definition.
4. hazard:
   - Hold `PCAdder_reg`, `Instruction_reg` and `Valid_reg`.
   - `StallCount` increments.
   - Next State = STALL.
5. Otherwise:
   - Load `PCAdder_In` and `Instruction_In`, `Valid_reg` <= 1.
   - Next State = RUN.

Combinational outputs:
- `PCWrite` = `Rst_n` & !(hazard & !`BranchTaken`).
- `Bubble` = !`Rst_n` | `BranchTaken` | hazard.
- While in FLUSH, `Bubble` = 0. The nop flowing through already carries zero control.

Counter rules:
- Both counters saturate at 2^`CNT_W` - 1 and never wrap.
- A BranchTaken that coincides with a hazard counts as a flush only; `StallCount` does not increment.

## Timing
- Latency: `Instruction_In` sampled at edge N appears on `Instruction_reg` after edge N.
- Load-use stall:
  - Lasts exactly 1 cycle.
  - The bubble enters ID/EX, so `IDEX_MemRead` drops to 0 at the next edge and the hazard clears without any extra logic.
  - STALL exits to RUN on the following edge.
- `BranchTaken` asserted in cycle N:
  - `Valid_reg` = 0 for cycles N+1 … N+`FLUSH_SLOTS`.
  - First valid instruction at cycle N+`FLUSH_SLOTS`+1.
- A `BranchTaken` arriving during FLUSH restarts the flush counter.
- Reset mid-stall or mid-flush: State = RUN and all registers cleared after the edge; no residual stall or flush.
- `PCWrite` and `Bubble` are valid in the same cycle as their inputs. No register sits in the PC-enable path.

## Structure
- Shared package holds:
  - state encodings `ST_RUN`, `ST_STALL`, `ST_FLUSH`
  - `NOP_INSTR` = 32'h0
  - field positions `RS_HI`/`RS_LO` (25/21) and `RT_HI`/`RT_LO` (20/16).
- One sub-module, `hazard_detect`: the pure combinational hazard compare. It is reused later by the forwarding unit.
- Perf counters are inline saturating increments; no sub-module.

## Test plan
- Reset: hold `Rst_n` = 0 for 2 cycles with random inputs -> all outputs 0, State = 0, `PCWrite` = 0, `Bubble` = 1; release -> `PCWrite` = 1.
- Pass-through: `Instruction_In` = 0x012A4020, `PCAdder_In` = 0x4 -> `Instruction_reg` = 0x012A4020, `PCAdder_reg` = 0x4, `Valid_reg` = 1 after the edge.
- Load-use: `Instruction_reg` = 0x01095020 (rs = 8), `IDEX_MemRead` = 1, `IDEX_Rt` = 8 -> `PCWrite` = 0, `Bubble` = 1, registers held one cycle, `StallCount` = 1. Then drop `IDEX_MemRead` -> RUN, load resumes.
- No false hazard: `IDEX_Rt` = 0 with `IDEX_MemRead` = 1 -> `PCWrite` = 1, no stall.
- Branch plus hazard simultaneously, `FLUSH_SLOTS` = 3 -> `PCWrite` = 1, `Valid_reg` = 0 for 3 cycles, `FlushCount` = 1, `StallCount` unchanged.
- Saturation: with `CNT_W` = 2, force 5 stalls -> `StallCount` = 3.
